apb_port_bridge: RTL
====================

# apb_port_bridge

Parametrised APB completer-to-requester bridge that replaces the fixed six-port APB slave stage between the core's APB master and the peripherals. It accepts one upstream APB transfer at a time and forwards it to one of `N_PORTS` peripheral ports over a registered SETUP/ACCESS sequence. It returns read data, ready and error upstream. Unlike the fixed stage, it adds an access timeout, error generation for unmapped ports and a saturating error counter.

## Interface
- `N_PORTS`, 6: number of peripheral ports (1..16).
- `ADDR_W`, 12: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum ACCESS cycles before forced error (1..255).
- `SEL_W`, `$clog2(N_PORTS)` (minimum 1): port-select width (derived).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `psel_in`  in  1  upstream select.
- `penable_in`  in  1  upstream enable.
- `pwrite_in`  in  1  1 = write, 0 = read.
- `sel_port`  in  SEL_W  target port index.
- `paddr_in`  in  ADDR_W  upstream address.
- `pwdata_in`  in  DATA_W  upstream write data.
- `pready_out`  out  1  upstream transfer complete.
- `prdata_out`  out  DATA_W  upstream read data.
- `pslverr_out`  out  1  upstream error, valid with `pready_out`.
- `psel_o`  out  N_PORTS  one-hot downstream select.
- `penable_o`  out  N_PORTS  one-hot downstream enable.
- `pwrite_o`  out  1  broadcast write flag.
- `paddr_o`  out  ADDR_W  broadcast address.
- `pwdata_o`  out  DATA_W  broadcast write data.
- `prdata_i`  in  N_PORTS*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
- `pready_i`  in  N_PORTS  per-port ready.
- `pslverr_i`  in  N_PORTS  per-port error.
- `err_count`  out  8  saturating count of errored transfers.

## Operation
FSM states: IDLE, SETUP, ACCESS, DONE.

- **IDLE**
  - Request detect: `psel_in=1` and `penable_in=0` at a rising edge.
  - On detect, capture `pwrite_in`, `paddr_in`, `pwdata_in` and `sel_port` into internal registers.
  - If `sel_port < N_PORTS`, go to SETUP. Otherwise go to DONE with error=1 and rdata=0 (unmapped port; no downstream activity).
- **SETUP**
  - `psel_o[port]=1`; all `penable_o`=0.
  - `pwrite_o`, `paddr_o` and `pwdata_o` drive the captured values.
  - Always goes to ACCESS after 1 cycle.
- **ACCESS**
  - `psel_o[port]=1` and `penable_o[port]=1`. The timeout counter is cleared on entry and increments each cycle.
  - If `pready_i[port]=1`: capture `prdata_i[port]` and `pslverr_i[port]`, then go to DONE.
  - Else, once the counter has reached `TIMEOUT` cycles in ACCESS: go to DONE with error=1 and rdata=0.
  - Ready has priority over timeout when both occur in the same cycle.
- **DONE**
  - `pready_out=1` for exactly 1 cycle, with `prdata_out`/`pslverr_out` valid.
  - Downstream `psel_o`/`penable_o` are all 0.
  - Returns to IDLE.
- **Read data:** `prdata_out` holds the last captured value. It is forced to 0 on writes and on errors.
- **`err_count`:** increments by 1 on entry to DONE with error=1 and saturates at 255.
- **Unused inputs:** other ports' `pready_i`/`pslverr_i` are ignored. Upstream inputs are ignored outside IDLE.
- **Upstream abort:** dropping `psel_in` mid-transfer is a protocol violation. The downstream sequence still completes, and the response is produced and dropped.
- **Exclusivity:** at most one bit of `psel_o` is ever high. `penable_o` is never high without the matching `psel_o`.

## Timing
- All outputs are registered.
- **Reset values:** `pready_out`, `pslverr_out`, `psel_o`, `penable_o` and `pwrite_o` = 0; `paddr_o`, `pwdata_o` and `prdata_out` = 0; `err_count` = 0; FSM = IDLE.
- **Reset mid-operation:** asserting `rst` at any point clears all outputs immediately (asynchronous), with no completion upstream.
- **Cycle sequence**, where edge E0 samples the setup phase:
  - E0+1: SETUP.
  - E0+2: ACCESS.
  - Zero-wait-state slave (`pready_i` high during the first ACCESS cycle): DONE/`pready_out` in the cycle after E0+3.
  - Each slave wait state adds 1 cycle.
- **Unmapped port:** `pready_out` in the cycle after E0+1.
- **Timeout:** error response appears `TIMEOUT+1` cycles after ACCESS entry.
- **Back-to-back transfers:** a new setup is accepted on the first edge back in IDLE, i.e. the cycle after DONE.

## Test plan
- **Write to port 2, zero wait:** `sel_port=2`, `paddr=0x010`, `pwdata=0xDEADBEEF`.
  - Required: `psel_o=6'b000100` for 2 cycles, `penable_o[2]` for 1 cycle.
  - `pwdata_o=0xDEADBEEF`; `pready_out=1`, `pslverr_out=0`, `prdata_out=0`.
- **Read from port 5 with 3 wait states:** `prdata_i[5]=0x12345678`.
  - Required: `pready_out` exactly 3 cycles later than the zero-wait case, with `prdata_out=0x12345678`.
- **Unmapped port:** `sel_port=7`, `N_PORTS=6`.
  - Required: no `psel_o` bit ever set; `pready_out` with `pslverr_out=1`; `err_count` 0→1.
- **Timeout:** `TIMEOUT=4`, port 0 never ready.
  - Required: `penable_o[0]` high for 5 cycles, then `pslverr_out=1` and `prdata_out=0`.
- **Slave error and saturation:** `pslverr_i[1]=1` with ready.
  - Required: `pslverr_out=1`.
  - Repeat 300 errored transfers: `err_count` holds at 255.
- **Async reset:** assert `rst` during ACCESS on port 3.
  - Required: `psel_o`/`penable_o` go to 0 the same cycle with no `pready_out`.
  - A subsequent transfer completes normally.

Source files
------------

// File: rtl/apb_port_bridge.sv
// APB bridge: one upstream transfer at a time, forwarded to one of N_PORTS
// downstream ports with access timeout, unmapped-port errors and an error counter.
module apb_port_bridge #(
    parameter int N_PORTS = 6,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int SEL_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel_in,
    input  logic                      penable_in,
    input  logic                      pwrite_in,
    input  logic [SEL_W-1:0]          sel_port,
    input  logic [ADDR_W-1:0]         paddr_in,
    input  logic [DATA_W-1:0]         pwdata_in,
    output logic                      pready_out,
    output logic [DATA_W-1:0]         prdata_out,
    output logic                      pslverr_out,
    output logic [N_PORTS-1:0]        psel_o,
    output logic [N_PORTS-1:0]        penable_o,
    output logic                      pwrite_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic [N_PORTS*DATA_W-1:0] prdata_i,
    input  logic [N_PORTS-1:0]        pready_i,
    input  logic [N_PORTS-1:0]        pslverr_i,
    output logic [7:0]                err_count
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SEL_W-1:0]    port_q, port_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_d;
    logic                pready_q, pslverr_q, pwrite_q;
    logic [N_PORTS-1:0]  psel_q, penable_q, psel_d, penable_d;
    logic [7:0]          errcnt_q, errcnt_d;

    logic [N_PORTS-1:0]  onehot;
    logic [DATA_W-1:0]   rd_sel;
    logic                rdy_sel, err_sel, mapped;

    // Port decode and response mux; only the captured port is ever observed.
    always_comb begin
        onehot  = '0;
        rd_sel  = '0;
        rdy_sel = 1'b0;
        err_sel = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (port_q == SEL_W'(k)) begin
                onehot[k] = 1'b1;
                rd_sel    = prdata_i[k*DATA_W +: DATA_W];
                rdy_sel   = pready_i[k];
                err_sel   = pslverr_i[k];
            end
        end
    end

    assign mapped = (int'(port_q) < N_PORTS);

    // The request is captured first and dispatched on the following edge,
    // so every output can be registered from the next state.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        port_d  = port_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_q) begin
                    req_d = 1'b0;
                    if (mapped) begin
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end else if (psel_in && !penable_in) begin
                    req_d   = 1'b1;
                    write_d = pwrite_in;
                    addr_d  = paddr_in;
                    wdata_d = pwdata_in;
                    port_d  = sel_port;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (rdy_sel) begin
                    state_d = DONE;
                    err_d   = err_sel;
                    rdata_d = (write_q || err_sel) ? '0 : rd_sel;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        psel_d    = (state_d == SETUP || state_d == ACCESS) ? onehot : '0;
        penable_d = (state_d == ACCESS) ? onehot : '0;
        errcnt_d  = errcnt_q;
        if (state_d == DONE && err_d && errcnt_q != 8'hFF)
            errcnt_d = errcnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            port_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= '0;
            errcnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            port_q    <= port_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            pready_q  <= (state_d == DONE);
            pslverr_q <= (state_d == DONE) && err_d;
            pwrite_q  <= write_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            errcnt_q  <= errcnt_d;
        end
    end

    assign pready_out  = pready_q;
    assign pslverr_out = pslverr_q;
    assign prdata_out  = rdata_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = addr_q;
    assign pwdata_o    = wdata_q;
    assign err_count   = errcnt_q;

endmodule
